hid_mc: RTL and testbench

- Parametrised multi-channel HID receiver for the IO MCU byte link.
- Decodes MCU command frames into:
  - a ROWS x COLS active-low keyboard matrix
  - NUM_JOY digital and analog joystick channels
  - numpad and special keys
  - a buffered mouse-event FIFO
- Monitors NUM_DB9 local DB9 ports and interrupts the MCU on any change.
- Sits between the MCU SPI byte deserialiser and the machine core's CIA, port and mouse logic.

---
 rtl/hid_mc.sv | 235 +++++++++++++++++++++++
 tb/tb_hid_mc.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hid_mc.sv
// hid_mc: multi-channel HID receiver for the IO MCU byte link.
// Frames decode into keyboard matrix, joysticks, numpad and a mouse FIFO.
module hid_mc #(
   parameter int NUM_JOY     = 2,
   parameter int NUM_DB9     = 1,
   parameter int ROWS        = 8,
   parameter int COLS        = 8,
   parameter int MFIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   data_in_strobe,
   input  logic                   data_in_start,
   input  logic [7:0]             data_in,
   output logic [7:0]             data_out,
   input  logic [6*NUM_DB9-1:0]   db9_port,
   output logic                   irq,
   input  logic                   iack,
   output logic [8*NUM_JOY-1:0]   joystick,
   output logic [8*NUM_JOY-1:0]   joystick_a0,
   output logic [8*NUM_JOY-1:0]   joystick_a1,
   output logic [7:0]             numpad,
   output logic                   mod_key,
   output logic                   key_restore,
   output logic                   tape_play,
   input  logic [ROWS-1:0]        keyboard_matrix_out,
   output logic [COLS-1:0]        keyboard_matrix_in,
   output logic                   mouse_valid,
   input  logic                   mouse_ready,
   output logic [1:0]             mouse_btns,
   output logic [7:0]             mouse_x,
   output logic [7:0]             mouse_y,
   output logic                   mouse_overflow
);

   localparam int AW = (MFIFO_DEPTH > 1) ? $clog2(MFIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   localparam logic [7:0] CMD_STATUS = 8'd0;
   localparam logic [7:0] CMD_KEY    = 8'd1;
   localparam logic [7:0] CMD_MOUSE  = 8'd2;
   localparam logic [7:0] CMD_JOY    = 8'd3;
   localparam logic [7:0] CMD_DB9    = 8'd4;
   localparam logic [7:0] CMD_HK     = 8'd5;

   localparam logic [7:0] NJ8  = 8'(NUM_JOY);
   localparam logic [3:0] NDB4 = 4'(NUM_DB9);

   logic [3:0] state;
   logic [7:0] cmd;
   logic       byte_ok;

   assign byte_ok = data_in_strobe && !data_in_start && (state != 4'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= 4'd0;
         cmd   <= 8'd0;
      end else if (data_in_strobe && data_in_start) begin
         state <= 4'd1;
         cmd   <= data_in;
      end else if (byte_ok && state != 4'd15) begin
         state <= state + 4'd1;
      end
   end

   // mouse FIFO signals, needed by the status reply
   logic [17:0]   mem [MFIFO_DEPTH];
   logic [17:0]   head;
   logic [17:0]   push_data;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] mcount;
   logic [1:0]    m_btns;
   logic [7:0]    m_x;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          full;
   logic          flush;

   logic [5:0] db9_sel;

   always_comb begin
      db9_sel = 6'd0;
      for (int p = 0; p < NUM_DB9; p++)
         if (state == 4'(p + 1)) db9_sel = db9_port[6*p +: 6];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= 8'd0;
      end else if (byte_ok) begin
         if (cmd == CMD_STATUS) begin
            case (state)
               4'd1:    data_out <= 8'h5C;
               4'd2:    data_out <= 8'h42;
               4'd3:    data_out <= NJ8;
               4'd4:    data_out <= {NDB4, 4'(mcount)};
               default: ;
            endcase
         end else if (cmd == CMD_DB9) begin
            data_out <= {2'b00, db9_sel};
         end
      end
   end

   logic [COLS-1:0] kb [ROWS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < ROWS; r++) kb[r] <= '1;
      end else if (byte_ok && cmd == CMD_KEY) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               if (data_in[2:0] == 3'(r) && data_in[5:3] == 3'(c))
                  kb[r][c] <= data_in[7];
      end else if (byte_ok && cmd == CMD_HK && state == 4'd1 && data_in[0]) begin
         for (int r = 0; r < ROWS; r++) kb[r] <= '1;
      end
   end

   always_comb begin
      keyboard_matrix_in = '1;
      for (int r = 0; r < ROWS; r++)
         if (!keyboard_matrix_out[r])
            keyboard_matrix_in = keyboard_matrix_in & kb[r];
   end

   logic [7:0] dev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dev         <= 8'd0;
         joystick    <= '0;
         joystick_a0 <= '0;
         joystick_a1 <= '0;
         numpad      <= 8'd0;
         m_btns      <= 2'd0;
         m_x         <= 8'd0;
      end else if (byte_ok) begin
         if (cmd == CMD_JOY) begin
            if (state == 4'd1) dev <= data_in;
            if (state == 4'd2 && dev == 8'h80) numpad <= data_in;
            for (int n = 0; n < NUM_JOY; n++) begin
               if (dev == 8'(n)) begin
                  case (state)
                     4'd2:    joystick[8*n +: 8]    <= data_in;
                     4'd3:    joystick_a0[8*n +: 8] <= data_in;
                     4'd4:    joystick_a1[8*n +: 8] <= data_in;
                     default: ;
                  endcase
               end
            end
         end else if (cmd == CMD_MOUSE) begin
            if (state == 4'd1) m_btns <= data_in[1:0];
            if (state == 4'd2) m_x <= data_in;
         end
      end
   end

   assign mod_key     = numpad[5];
   assign key_restore = numpad[6];
   assign tape_play   = numpad[7];

   assign push_req    = byte_ok && cmd == CMD_MOUSE && state == 4'd3;
   assign full        = mcount == CW'(MFIFO_DEPTH);
   assign mouse_valid = mcount != '0;
   assign pop         = mouse_valid && mouse_ready;
   assign push        = push_req && (!full || pop);
   assign flush       = byte_ok && cmd == CMD_HK && state == 4'd1 && data_in[1];
   assign push_data   = {m_btns, m_x, data_in};

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   // head tracks the oldest entry so consumers see registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         mcount         <= '0;
         mouse_overflow <= 1'b0;
         head           <= '0;
      end else if (flush) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         mcount         <= '0;
         mouse_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop) mcount <= mcount + CW'(1);
         else if (pop && !push) mcount <= mcount - CW'(1);
         if (push_req && !push) mouse_overflow <= 1'b1;
         if (pop) begin
            if (mcount > CW'(1)) head <= mem[rd_ptr + AW'(1)];
            else if (push) head <= push_data;
         end else if (push && !mouse_valid) begin
            head <= push_data;
         end
      end
   end

   assign mouse_btns = head[17:16];
   assign mouse_x    = head[15:8];
   assign mouse_y    = head[7:0];

   logic [6*NUM_DB9-1:0] shadow;
   logic                 armed;
   logic                 primed;
   logic                 rearm;
   logic                 change;

   assign rearm  = byte_ok && cmd == CMD_DB9 && state == 4'd1;
   assign change = armed && (db9_port != shadow);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow <= '0;
         armed  <= 1'b0;
         primed <= 1'b0;
         irq    <= 1'b0;
      end else begin
         primed <= 1'b1;
         if (!primed || armed || rearm) shadow <= db9_port;
         if (change) armed <= 1'b0;
         else if (rearm) armed <= 1'b1;
         if (change) irq <= 1'b1;
         else if (iack) irq <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hid_mc.sv
// tb_hid_mc: directed self-checking bench for hid_mc.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hid_mc;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        data_in_strobe;
   logic        data_in_start;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic [5:0]  db9_port;
   logic        irq;
   logic        iack;
   logic [15:0] joystick;
   logic [15:0] joystick_a0;
   logic [15:0] joystick_a1;
   logic [7:0]  numpad;
   logic        mod_key;
   logic        key_restore;
   logic        tape_play;
   logic [7:0]  keyboard_matrix_out;
   logic [7:0]  keyboard_matrix_in;
   logic        mouse_valid;
   logic        mouse_ready;
   logic [1:0]  mouse_btns;
   logic [7:0]  mouse_x;
   logic [7:0]  mouse_y;
   logic        mouse_overflow;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hid_mc #(
      .NUM_JOY(2), .NUM_DB9(1), .ROWS(8), .COLS(8), .MFIFO_DEPTH(4)
   ) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .data_in_strobe      (data_in_strobe),
      .data_in_start       (data_in_start),
      .data_in             (data_in),
      .data_out            (data_out),
      .db9_port            (db9_port),
      .irq                 (irq),
      .iack                (iack),
      .joystick            (joystick),
      .joystick_a0         (joystick_a0),
      .joystick_a1         (joystick_a1),
      .numpad              (numpad),
      .mod_key             (mod_key),
      .key_restore         (key_restore),
      .tape_play           (tape_play),
      .keyboard_matrix_out (keyboard_matrix_out),
      .keyboard_matrix_in  (keyboard_matrix_in),
      .mouse_valid         (mouse_valid),
      .mouse_ready         (mouse_ready),
      .mouse_btns          (mouse_btns),
      .mouse_x             (mouse_x),
      .mouse_y             (mouse_y),
      .mouse_overflow      (mouse_overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // called on a falling edge; returns on the next falling edge
   task automatic send(input logic start, input logic [7:0] b);
      data_in_strobe = 1'b1;
      data_in_start  = start;
      data_in        = b;
      @(negedge clk);
      data_in_strobe = 1'b0;
      data_in_start  = 1'b0;
   endtask

   task automatic mouse_frame(input logic [7:0] bt, input logic [7:0] x,
                              input logic [7:0] y);
      send(1'b1, 8'h02);
      send(1'b0, bt);
      send(1'b0, x);
      send(1'b0, y);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset_n             = 1'b0;
      data_in_strobe      = 1'b0;
      data_in_start       = 1'b0;
      data_in             = 8'h00;
      db9_port            = 6'h00;
      iack                = 1'b0;
      keyboard_matrix_out = 8'h00;
      mouse_ready         = 1'b0;

      tick(2);
      check("rst_kbd_all_rows", 32'(keyboard_matrix_in), 32'hFF);
      check("rst_data_out", 32'(data_out), 32'h00);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_joy", 32'(joystick), 32'h0);
      check("rst_numpad", 32'(numpad), 32'h0);
      check("rst_mvalid", 32'(mouse_valid), 32'h0);
      check("rst_movf", 32'(mouse_overflow), 32'h0);
      reset_n = 1'b1;
      keyboard_matrix_out = 8'hFF;
      tick(2);

      // keyboard events
      send(1'b1, 8'h01);
      send(1'b0, 8'h09);
      keyboard_matrix_out = 8'hFD;
      #1 check("kbd_r1c1_press", 32'(keyboard_matrix_in), 32'hFD);
      send(1'b0, 8'h8A);
      check("kbd_r1_after_rel", 32'(keyboard_matrix_in), 32'hFD);
      keyboard_matrix_out = 8'hFB;
      #1 check("kbd_r2_released", 32'(keyboard_matrix_in), 32'hFF);
      keyboard_matrix_out = 8'hFF;
      #1 check("kbd_no_row", 32'(keyboard_matrix_in), 32'hFF);
      keyboard_matrix_out = 8'hFD;
      tick(1);

      // joystick channel 1
      send(1'b1, 8'h03);
      send(1'b0, 8'h01);
      send(1'b0, 8'h15);
      send(1'b0, 8'h80);
      send(1'b0, 8'h7F);
      check("joy_dig", 32'(joystick), 32'h1500);
      check("joy_a0", 32'(joystick_a0), 32'h8000);
      check("joy_a1", 32'(joystick_a1), 32'h7F00);

      // numpad via device 0x80
      send(1'b1, 8'h03);
      send(1'b0, 8'h80);
      send(1'b0, 8'hA0);
      check("numpad", 32'(numpad), 32'hA0);
      check("numpad_bits", 32'({tape_play, key_restore, mod_key}), 32'b101);

      // unknown device ignored
      send(1'b1, 8'h03);
      send(1'b0, 8'h05);
      send(1'b0, 8'h33);
      check("joy_bad_dev", 32'(joystick), 32'h1500);

      // five mouse frames into a 4-deep FIFO
      for (int i = 1; i <= 5; i++)
         mouse_frame(8'(i & 3), 8'(8'h10 + i), 8'(8'h20 + i));
      check("mouse_valid_full", 32'(mouse_valid), 32'h1);
      check("mouse_ovf", 32'(mouse_overflow), 32'h1);
      check("mouse_head1", 32'({mouse_btns, mouse_x, mouse_y}), 32'h11121);
      send(1'b1, 8'h00);
      send(1'b0, 8'h00);
      check("stat_id0", 32'(data_out), 32'h5C);
      send(1'b0, 8'h00);
      check("stat_id1", 32'(data_out), 32'h42);
      send(1'b0, 8'h00);
      check("stat_njoy", 32'(data_out), 32'h02);
      send(1'b0, 8'h00);
      check("stat_count4", 32'(data_out), 32'h14);

      mouse_ready = 1'b1;
      tick(1);
      check("pop_head2", 32'({mouse_btns, mouse_x, mouse_y}), 32'h21222);
      tick(1);
      check("pop_head3", 32'({mouse_btns, mouse_x, mouse_y}), 32'h31323);
      tick(1);
      check("pop_head4", 32'({mouse_btns, mouse_x, mouse_y}), 32'h01424);
      check("pop_valid_hi", 32'(mouse_valid), 32'h1);
      tick(1);
      check("pop_empty", 32'(mouse_valid), 32'h0);
      check("head_hold", 32'({mouse_btns, mouse_x, mouse_y}), 32'h01424);
      mouse_ready = 1'b0;
      check("ovf_sticky", 32'(mouse_overflow), 32'h1);

      send(1'b1, 8'h05);
      send(1'b0, 8'h02);
      check("ovf_clear", 32'(mouse_overflow), 32'h0);

      // push on empty, then simultaneous push/pop on full
      mouse_frame(8'h02, 8'h31, 8'h41);
      check("push_empty_valid", 32'(mouse_valid), 32'h1);
      check("push_empty_head", 32'({mouse_btns, mouse_x, mouse_y}), 32'h23141);
      mouse_frame(8'h03, 8'h32, 8'h42);
      mouse_frame(8'h00, 8'h33, 8'h43);
      mouse_frame(8'h01, 8'h34, 8'h44);
      send(1'b1, 8'h02);
      send(1'b0, 8'h02);
      send(1'b0, 8'h35);
      mouse_ready = 1'b1;
      send(1'b0, 8'h45);
      mouse_ready = 1'b0;
      check("pushpop_no_ovf", 32'(mouse_overflow), 32'h0);
      check("pushpop_head", 32'({mouse_btns, mouse_x, mouse_y}), 32'h33242);
      send(1'b1, 8'h00);
      repeat (4) send(1'b0, 8'h00);
      check("pushpop_count", 32'(data_out), 32'h14);

      // flush plus key release
      send(1'b1, 8'h05);
      send(1'b0, 8'h03);
      check("flush_empty", 32'(mouse_valid), 32'h0);
      check("release_all", 32'(keyboard_matrix_in), 32'hFF);

      // aborted mouse frame commits nothing
      send(1'b1, 8'h02);
      send(1'b0, 8'h01);
      send(1'b0, 8'h55);
      send(1'b1, 8'h00);
      send(1'b0, 8'h00);
      check("abort_st1", 32'(data_out), 32'h5C);
      send(1'b0, 8'h00);
      check("abort_st2", 32'(data_out), 32'h42);
      send(1'b0, 8'h00);
      check("abort_st3", 32'(data_out), 32'h02);
      send(1'b0, 8'h00);
      check("abort_count0", 32'(data_out), 32'h10);
      check("abort_no_valid", 32'(mouse_valid), 32'h0);

      // not armed after reset: changes ignored
      db9_port = 6'h01;
      tick(2);
      check("irq_unarmed", 32'(irq), 32'h0);

      // arm, read port, then extra state reads zero
      send(1'b1, 8'h04);
      send(1'b0, 8'h00);
      check("db9_read", 32'(data_out), 32'h01);
      send(1'b0, 8'h00);
      check("db9_state2_zero", 32'(data_out), 32'h00);
      db9_port = 6'h05;
      tick(1);
      check("irq_set", 32'(irq), 32'h1);
      db9_port = 6'h01;
      tick(2);
      check("irq_hold", 32'(irq), 32'h1);
      iack = 1'b1;
      tick(1);
      iack = 1'b0;
      check("irq_iack", 32'(irq), 32'h0);
      db9_port = 6'h03;
      tick(2);
      check("irq_no_rearm", 32'(irq), 32'h0);

      send(1'b1, 8'h04);
      send(1'b0, 8'h00);
      check("db9_read2", 32'(data_out), 32'h03);
      db9_port = 6'h07;
      iack = 1'b1;
      tick(1);
      iack = 1'b0;
      check("irq_set_beats_iack", 32'(irq), 32'h1);

      // async reset in the middle of a joystick frame
      send(1'b1, 8'h03);
      send(1'b0, 8'h00);
      send(1'b0, 8'hAA);
      check("pre_rst_joy", 32'(joystick), 32'h15AA);
      #2 reset_n = 1'b0;
      #1;
      check("arst_joy", 32'(joystick), 32'h0);
      check("arst_a0a1", 32'({joystick_a0, joystick_a1}), 32'h0);
      check("arst_numpad", 32'({numpad, tape_play, key_restore, mod_key}), 32'h0);
      check("arst_data_out", 32'(data_out), 32'h00);
      check("arst_irq", 32'(irq), 32'h0);
      check("arst_mouse", 32'({mouse_valid, mouse_overflow}), 32'h0);
      check("arst_kbd", 32'(keyboard_matrix_in), 32'hFF);
      tick(2);
      reset_n = 1'b1;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
